// File: rtl/ga21_pal_dma_if.sv
// Palette DMA bundle: CPU register port, vblank, source-read handshake and
// the GA21 palette-write side. The engine uses the master modport.
interface ga21_pal_dma_if #(
  parameter int unsigned SRC_W = 16,
  parameter int unsigned DST_W = 13
) ();
  logic             reg_wr;
  logic [1:0]       reg_addr;
  logic [15:0]      reg_din;
  logic             vblank;
  logic             src_req;
  logic [SRC_W-1:0] src_addr;
  logic             src_ack;
  logic [15:0]      src_data;
  logic [DST_W-1:0] ga21_addr;
  logic             ga21_we;
  logic             ga21_req;
  logic [15:0]      ga21_dout;
  logic             dma_busy;
  logic             dma_done;

  modport master (
    input  reg_wr, reg_addr, reg_din, vblank, src_ack, src_data,
    output src_req, src_addr, ga21_addr, ga21_we, ga21_req, ga21_dout, dma_busy, dma_done
  );

  modport slave (
    output reg_wr, reg_addr, reg_din, vblank, src_ack, src_data,
    input  src_req, src_addr, ga21_addr, ga21_we, ga21_req, ga21_dout, dma_busy, dma_done
  );
endinterface

// File: rtl/ga21_pal_dma.sv
// Palette DMA engine: copies a block of 16-bit words from work RAM into
// palette RAM one word at a time, started by a CPU control write or by a
// vblank rising edge when auto-arm is set.
module ga21_pal_dma #(
  parameter int unsigned SRC_W = 16,
  parameter int unsigned DST_W = 13,
  parameter int unsigned LEN_W = 12
) (
  input logic            clk,
  input logic            reset_n,
  ga21_pal_dma_if.master bus
);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StRead,
    StWrite,
    StTail,
    StDone
  } state_e;

  // Shadow registers (CPU visible)
  logic [SRC_W-1:0] r_src_base;
  logic [DST_W-1:0] r_dst_base;
  logic [LEN_W-1:0] r_length;
  logic             r_auto_arm;
  logic             r_vblank_d;

  // Working copies, only touched by the FSM
  logic [SRC_W-1:0] r_src_cnt;
  logic [DST_W-1:0] r_dst_cnt;
  logic [LEN_W-1:0] r_remaining;
  state_e           r_state;

  // Registered outputs
  logic             r_src_req;
  logic [DST_W-1:0] r_ga21_addr;
  logic             r_ga21_we;
  logic             r_ga21_req;
  logic [15:0]      r_ga21_dout;
  logic             r_dma_busy;
  logic             r_dma_done;

  logic w_start;
  logic w_vb_edge;
  logic w_trigger;

  assign w_start   = bus.reg_wr && (bus.reg_addr == 2'd3) && bus.reg_din[0];
  assign w_vb_edge = bus.vblank && !r_vblank_d;
  // Only meaningful in StIdle; the FSM drops it everywhere else.
  assign w_trigger = w_start || (w_vb_edge && r_auto_arm);

  // CPU shadow register writes; always accepted, even mid-transfer.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_src_base <= '0;
      r_dst_base <= '0;
      r_length   <= '0;
      r_auto_arm <= 1'b0;
    end else if (bus.reg_wr) begin
      unique case (bus.reg_addr)
        2'd0: r_src_base <= bus.reg_din[SRC_W-1:0];
        2'd1: r_dst_base <= bus.reg_din[DST_W-1:0];
        2'd2: r_length   <= bus.reg_din[LEN_W-1:0];
        2'd3: r_auto_arm <= bus.reg_din[1];
        default: ;
      endcase
    end
  end

  // Delayed vblank copy for rising-edge detection.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_vblank_d <= 1'b0;
    end else begin
      r_vblank_d <= bus.vblank;
    end
  end

  // Transfer FSM; outputs are set on entry so they are valid during each state.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state     <= StIdle;
      r_src_cnt   <= '0;
      r_dst_cnt   <= '0;
      r_remaining <= '0;
      r_src_req   <= 1'b0;
      r_ga21_addr <= '0;
      r_ga21_we   <= 1'b0;
      r_ga21_req  <= 1'b0;
      r_ga21_dout <= '0;
      r_dma_busy  <= 1'b0;
      r_dma_done  <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_trigger) begin
            r_state    <= StLoad;
            r_dma_busy <= 1'b1;
          end
        end
        StLoad: begin
          // Shadows are read here, one edge after the trigger write.
          r_src_cnt   <= r_src_base;
          r_dst_cnt   <= r_dst_base;
          r_remaining <= r_length;
          r_ga21_req  <= 1'b1;
          if (r_length == '0) begin
            r_state <= StTail;
          end else begin
            r_state   <= StRead;
            r_src_req <= 1'b1;
          end
        end
        StRead: begin
          if (bus.src_ack) begin
            r_ga21_dout <= bus.src_data;
            r_ga21_addr <= r_dst_cnt;
            r_ga21_we   <= 1'b1;
            r_src_req   <= 1'b0;
            r_state     <= StWrite;
          end
        end
        StWrite: begin
          r_ga21_we   <= 1'b0;
          r_src_cnt   <= r_src_cnt + SRC_W'(1);
          r_dst_cnt   <= r_dst_cnt + DST_W'(1);
          r_remaining <= r_remaining - LEN_W'(1);
          if (r_remaining == LEN_W'(1)) begin
            r_state <= StTail;
          end else begin
            r_state   <= StRead;
            r_src_req <= 1'b1;
          end
        end
        StTail: begin
          // Extra busy cycle lets the palette stage's write pipeline drain.
          r_ga21_req <= 1'b0;
          r_dma_busy <= 1'b0;
          r_dma_done <= 1'b1;
          r_state    <= StDone;
        end
        StDone: begin
          r_dma_done <= 1'b0;
          r_state    <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  // src_addr tracks the working source pointer directly.
  assign bus.src_req   = r_src_req;
  assign bus.src_addr  = r_src_cnt;
  assign bus.ga21_addr = r_ga21_addr;
  assign bus.ga21_we   = r_ga21_we;
  assign bus.ga21_req  = r_ga21_req;
  assign bus.ga21_dout = r_ga21_dout;
  assign bus.dma_busy  = r_dma_busy;
  assign bus.dma_done  = r_dma_done;

endmodule

// File: tb/tb_ga21_pal_dma.sv
// Self-checking bench for ga21_pal_dma: a source-RAM responder with a
// configurable ack delay, a negedge monitor logging palette writes, and a
// reference model that derives expected words and cycle counts from the
// transfer parameters.
module tb_ga21_pal_dma;
  localparam int unsigned SRC_W = 16;
  localparam int unsigned DST_W = 13;
  localparam int unsigned LEN_W = 12;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  ga21_pal_dma_if #(.SRC_W(SRC_W), .DST_W(DST_W)) bus ();

  ga21_pal_dma #(.SRC_W(SRC_W), .DST_W(DST_W), .LEN_W(LEN_W)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Source memory behaviour: word at address a reads as a + g_data_add.
  int unsigned g_delay = 0;
  logic [15:0] g_data_add = 16'h0;

  // Monitor accumulators (written only by the monitor process)
  int unsigned cyc = 0, busy_cyc = 0, req_cyc = 0, srcreq_cyc = 0;
  int unsigned we_cnt = 0, done_cnt = 0, viol = 0;
  int unsigned trig_cyc = 0, vb_cyc = 0, done_cyc = 0;
  logic [DST_W+15:0] wr_log[$];
  logic [15:0] src_log[$];
  logic prev_src_req = 1'b0, prev_vb = 1'b0;
  int unsigned wait_cnt = 0;

  // Snapshots taken before each scenario
  int unsigned s_busy, s_req, s_srcreq, s_we, s_done, s_viol, s_wr, s_src;

  // Monitor then source responder, both on the falling edge.
  always @(negedge clk) begin
    cyc++;
    if (bus.dma_busy) busy_cyc++;
    if (bus.ga21_req) req_cyc++;
    if (bus.src_req) srcreq_cyc++;
    if (bus.ga21_we) begin
      we_cnt++;
      wr_log.push_back({bus.ga21_addr, bus.ga21_dout});
      if (bus.src_req) viol++;
    end
    if (bus.dma_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (bus.src_req && !prev_src_req) src_log.push_back(bus.src_addr);
    if (bus.reg_wr && bus.reg_addr == 2'd3 && bus.reg_din[0]) trig_cyc = cyc;
    if (bus.vblank && !prev_vb) vb_cyc = cyc;
    prev_src_req = bus.src_req;
    prev_vb = bus.vblank;
    if (bus.src_req && bus.src_ack !== 1'b1) begin
      if (wait_cnt >= g_delay) begin
        bus.src_ack = 1'b1;
        bus.src_data = bus.src_addr + g_data_add;
      end else begin
        wait_cnt++;
        bus.src_ack = 1'b0;
        bus.src_data = 16'($urandom);
      end
    end else begin
      bus.src_ack = 1'b0;
      bus.src_data = 16'($urandom);
      wait_cnt = 0;
    end
  end

  function automatic logic [DST_W+15:0] exp_wr(input int unsigned src, input int unsigned dst,
                                                input int unsigned add, input int unsigned i);
    logic [DST_W-1:0] a;
    logic [15:0] d;
    a = DST_W'((dst + i) % 8192);
    d = 16'((((src + i) % 65536) + add) % 65536);
    return {a, d};
  endfunction

  function automatic logic [DST_W+15:0] got_wr(input int unsigned k);
    if (int'(k) < wr_log.size()) return wr_log[k];
    return 'x;
  endfunction

  task automatic idle(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr_reg(input logic [1:0] a, input logic [15:0] d);
    @(posedge clk);
    #1;
    bus.reg_wr = 1'b1;
    bus.reg_addr = a;
    bus.reg_din = d;
    @(posedge clk);
    #1;
    bus.reg_wr = 1'b0;
  endtask

  task automatic program_regs(input logic [15:0] src, input logic [15:0] dst,
                              input logic [15:0] len);
    wr_reg(2'd0, src);
    wr_reg(2'd1, dst);
    wr_reg(2'd2, len);
  endtask

  task automatic snap();
    s_busy = busy_cyc; s_req = req_cyc; s_srcreq = srcreq_cyc; s_we = we_cnt;
    s_done = done_cnt; s_viol = viol; s_wr = wr_log.size(); s_src = src_log.size();
  endtask

  task automatic wait_done(input int unsigned limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < int'(limit) && !ok; i++) begin
      @(negedge clk);
      #1;
      if (done_cnt != s_done) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({bus.src_req, bus.ga21_we, bus.ga21_req, bus.dma_busy, bus.dma_done, bus.src_addr,
         bus.ga21_addr, bus.ga21_dout} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got src_req=%b we=%b req=%b busy=%b done=%b sa=%h ga=%h gd=%h exp all 0",
               bus.src_req, bus.ga21_we, bus.ga21_req, bus.dma_busy, bus.dma_done,
               bus.src_addr, bus.ga21_addr, bus.ga21_dout);
    end
    reset_n = 1'b1;
    idle(2);
  endtask

  task automatic test_basic();
    bit ok;
    int unsigned t0;
    g_delay = 0;
    g_data_add = 16'hA000 - 16'h0100;
    snap();
    program_regs(16'h0100, 16'h0010, 16'd4);
    wr_reg(2'd3, 16'h0001);
    t0 = trig_cyc;
    wait_done(100, ok);
    idle(6);
    checks++;
    if (!ok) begin errors++; $display("FAIL basic_done got timeout exp pulse"); end
    checks++;
    if (done_cnt - s_done != 1) begin
      errors++; $display("FAIL basic_done_count got %0d exp 1", done_cnt - s_done);
    end
    checks++;
    if (we_cnt - s_we != 4) begin
      errors++; $display("FAIL basic_we_count got %0d exp 4", we_cnt - s_we);
    end
    checks++;
    if (busy_cyc - s_busy != 10) begin
      errors++; $display("FAIL basic_busy_cycles got %0d exp 10", busy_cyc - s_busy);
    end
    checks++;
    if (req_cyc - s_req != 9) begin
      errors++; $display("FAIL basic_req_cycles got %0d exp 9", req_cyc - s_req);
    end
    checks++;
    if (done_cyc - t0 != 11) begin
      errors++; $display("FAIL basic_latency got %0d exp 11", done_cyc - t0);
    end
    for (int unsigned i = 0; i < 4; i++) begin
      checks++;
      if (got_wr(s_wr + i) !== exp_wr(32'h100, 32'h10, 32'(g_data_add), i)) begin
        errors++;
        $display("FAIL basic_write%0d got %h exp %h", i, got_wr(s_wr + i),
                 exp_wr(32'h100, 32'h10, 32'(g_data_add), i));
      end
    end
  endtask

  task automatic test_wrap();
    bit ok;
    logic [15:0] exp_src[3];
    exp_src[0] = 16'hFFFF; exp_src[1] = 16'h0000; exp_src[2] = 16'h0001;
    g_delay = 1;
    g_data_add = 16'h1234;
    snap();
    program_regs(16'hFFFF, 16'h1FFE, 16'd3);
    wr_reg(2'd3, 16'h0001);
    wait_done(100, ok);
    idle(4);
    checks++;
    if (!ok || we_cnt - s_we != 3) begin
      errors++; $display("FAIL wrap_we_count got %0d exp 3 (done=%0d)", we_cnt - s_we, ok);
    end
    for (int unsigned i = 0; i < 3; i++) begin
      checks++;
      if (got_wr(s_wr + i) !== exp_wr(32'hFFFF, 32'h1FFE, 32'h1234, i)) begin
        errors++;
        $display("FAIL wrap_write%0d got %h exp %h", i, got_wr(s_wr + i),
                 exp_wr(32'hFFFF, 32'h1FFE, 32'h1234, i));
      end
      checks++;
      if (int'(s_src + i) >= src_log.size() || src_log[s_src + i] !== exp_src[i]) begin
        errors++;
        $display("FAIL wrap_src_addr%0d got %h exp %h", i,
                 (int'(s_src + i) < src_log.size()) ? src_log[s_src + i] : 16'hxxxx, exp_src[i]);
      end
    end
  endtask

  task automatic test_zero_len();
    bit ok;
    int unsigned t0;
    snap();
    program_regs(16'h0040, 16'h0080, 16'd0);
    wr_reg(2'd3, 16'h0001);
    t0 = trig_cyc;
    wait_done(50, ok);
    idle(4);
    checks++;
    if (!ok || done_cnt - s_done != 1) begin
      errors++; $display("FAIL zero_done got %0d exp 1", done_cnt - s_done);
    end
    checks++;
    if (busy_cyc - s_busy != 2) begin
      errors++; $display("FAIL zero_busy got %0d exp 2", busy_cyc - s_busy);
    end
    checks++;
    if (srcreq_cyc - s_srcreq != 0 || we_cnt - s_we != 0) begin
      errors++;
      $display("FAIL zero_activity got src_req=%0d we=%0d exp 0 0", srcreq_cyc - s_srcreq,
               we_cnt - s_we);
    end
    checks++;
    if (done_cyc - t0 != 3) begin
      errors++; $display("FAIL zero_latency got %0d exp 3", done_cyc - t0);
    end
  endtask

  task automatic test_wait_ignore();
    bit ok;
    int unsigned t0;
    g_delay = 3;
    g_data_add = 16'h0F00;
    snap();
    program_regs(16'h0200, 16'h0300, 16'd2);
    wr_reg(2'd3, 16'h0001);
    t0 = trig_cyc;
    idle(2);
    wr_reg(2'd3, 16'h0001);  // lands while the first word is still waiting
    wait_done(100, ok);
    idle(15);
    checks++;
    if (!ok || done_cnt - s_done != 1) begin
      errors++; $display("FAIL wait_done_count got %0d exp 1", done_cnt - s_done);
    end
    checks++;
    if (srcreq_cyc - s_srcreq != 8) begin
      errors++; $display("FAIL wait_src_req_cycles got %0d exp 8", srcreq_cyc - s_srcreq);
    end
    checks++;
    if (viol - s_viol != 0) begin
      errors++; $display("FAIL wait_we_during_req got %0d exp 0", viol - s_viol);
    end
    checks++;
    if (we_cnt - s_we != 2) begin
      errors++; $display("FAIL wait_we_count got %0d exp 2", we_cnt - s_we);
    end
    checks++;
    if (done_cyc - t0 != 13) begin
      errors++; $display("FAIL wait_latency got %0d exp 13", done_cyc - t0);
    end
  endtask

  task automatic test_vblank();
    bit ok;
    g_delay = 0;
    g_data_add = 16'h0;
    program_regs(16'h0020, 16'h0100, 16'd2);
    wr_reg(2'd3, 16'h0002);
    snap();
    bus.vblank = 1'b1;
    wait_done(50, ok);
    checks++;
    if (!ok || done_cyc - vb_cyc != 7) begin
      errors++; $display("FAIL vblank_first_latency got %0d exp 7", done_cyc - vb_cyc);
    end
    idle(12);  // held high: no retrigger
    checks++;
    if (done_cnt - s_done != 1) begin
      errors++; $display("FAIL vblank_held got %0d exp 1", done_cnt - s_done);
    end
    bus.vblank = 1'b0;
    idle(3);
    bus.vblank = 1'b1;
    idle(20);
    checks++;
    if (done_cnt - s_done != 2 || we_cnt - s_we != 4) begin
      errors++;
      $display("FAIL vblank_second got done=%0d we=%0d exp 2 4", done_cnt - s_done, we_cnt - s_we);
    end
    wr_reg(2'd3, 16'h0000);
    bus.vblank = 1'b0;
    idle(3);
    bus.vblank = 1'b1;
    idle(20);
    checks++;
    if (done_cnt - s_done != 2) begin
      errors++; $display("FAIL vblank_disarmed got %0d exp 2", done_cnt - s_done);
    end
    bus.vblank = 1'b0;
    idle(3);
  endtask

  task automatic test_same_cycle();
    bit ok;
    g_delay = 0;
    g_data_add = 16'h7700;
    program_regs(16'h0500, 16'h0200, 16'd2);
    wr_reg(2'd3, 16'h0002);
    snap();
    // Length write coincides with the vblank trigger: LOAD sees the new length.
    @(posedge clk);
    #1;
    bus.reg_wr = 1'b1; bus.reg_addr = 2'd2; bus.reg_din = 16'd5; bus.vblank = 1'b1;
    @(posedge clk);
    #1;
    bus.reg_wr = 1'b0;
    wait_done(100, ok);
    idle(4);
    checks++;
    if (!ok || we_cnt - s_we != 5) begin
      errors++; $display("FAIL newlen_we_count got %0d exp 5", we_cnt - s_we);
    end
    checks++;
    if (got_wr(s_wr + 4) !== exp_wr(32'h500, 32'h200, 32'h7700, 4)) begin
      errors++;
      $display("FAIL newlen_last_write got %h exp %h", got_wr(s_wr + 4),
               exp_wr(32'h500, 32'h200, 32'h7700, 4));
    end
    bus.vblank = 1'b0;
    idle(3);
    snap();
    // Start write and vblank edge together: one transfer.
    @(posedge clk);
    #1;
    bus.reg_wr = 1'b1; bus.reg_addr = 2'd3; bus.reg_din = 16'h0003; bus.vblank = 1'b1;
    @(posedge clk);
    #1;
    bus.reg_wr = 1'b0;
    wait_done(100, ok);
    idle(20);
    checks++;
    if (done_cnt - s_done != 1 || we_cnt - s_we != 5) begin
      errors++;
      $display("FAIL dual_trigger got done=%0d we=%0d exp 1 5", done_cnt - s_done, we_cnt - s_we);
    end
    wr_reg(2'd3, 16'h0000);
    bus.vblank = 1'b0;
    idle(3);
  endtask

  task automatic test_reset_mid();
    bit ok;
    bit seen;
    g_delay = 3;
    g_data_add = 16'h0;
    program_regs(16'h0300, 16'h0040, 16'd8);
    snap();
    wr_reg(2'd3, 16'h0001);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      #1;
      if (bus.src_req) seen = 1'b1;
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL rstmid_reach_read got 0 exp 1"); end
    reset_n = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if ({bus.src_req, bus.ga21_we, bus.ga21_req, bus.dma_busy, bus.dma_done, bus.src_addr,
         bus.ga21_addr, bus.ga21_dout} !== '0) begin
      errors++;
      $display("FAIL rstmid_outputs got src_req=%b we=%b req=%b busy=%b done=%b sa=%h ga=%h gd=%h exp all 0",
               bus.src_req, bus.ga21_we, bus.ga21_req, bus.dma_busy, bus.dma_done,
               bus.src_addr, bus.ga21_addr, bus.ga21_dout);
    end
    reset_n = 1'b1;
    idle(20);
    checks++;
    if (done_cnt - s_done != 0 || busy_cyc - s_busy > 4) begin
      errors++;
      $display("FAIL rstmid_aborted got done=%0d busy=%0d exp 0 <=4", done_cnt - s_done,
               busy_cyc - s_busy);
    end
    g_delay = 0;
    g_data_add = 16'h4400;
    snap();
    program_regs(16'h0310, 16'h0050, 16'd2);
    wr_reg(2'd3, 16'h0001);
    wait_done(50, ok);
    idle(4);
    checks++;
    if (!ok || got_wr(s_wr + 1) !== exp_wr(32'h310, 32'h50, 32'h4400, 1)) begin
      errors++;
      $display("FAIL rstmid_fresh got %h exp %h", got_wr(s_wr + 1),
               exp_wr(32'h310, 32'h50, 32'h4400, 1));
    end
  endtask

  task automatic test_random();
    bit ok;
    int unsigned src, dst, len, dly, t0;
    for (int it = 0; it < 6; it++) begin
      src = $urandom_range(0, 65535);
      dst = $urandom_range(0, 8191);
      len = $urandom_range(1, 6);
      dly = $urandom_range(0, 2);
      g_delay = dly;
      g_data_add = 16'($urandom);
      snap();
      program_regs(16'(src), 16'(dst), 16'(len));
      wr_reg(2'd3, 16'h0001);
      t0 = trig_cyc;
      wait_done(200, ok);
      idle(4);
      checks++;
      if (!ok || we_cnt - s_we != len) begin
        errors++; $display("FAIL rand%0d_we_count got %0d exp %0d", it, we_cnt - s_we, len);
      end
      checks++;
      if (busy_cyc - s_busy != 2 + 2 * len + len * dly) begin
        errors++;
        $display("FAIL rand%0d_busy got %0d exp %0d", it, busy_cyc - s_busy,
                 2 + 2 * len + len * dly);
      end
      checks++;
      if (done_cyc - t0 != 3 + 2 * len + len * dly) begin
        errors++;
        $display("FAIL rand%0d_latency got %0d exp %0d", it, done_cyc - t0,
                 3 + 2 * len + len * dly);
      end
      for (int unsigned i = 0; i < len; i++) begin
        checks++;
        if (got_wr(s_wr + i) !== exp_wr(src, dst, 32'(g_data_add), i)) begin
          errors++;
          $display("FAIL rand%0d_write%0d got %h exp %h", it, i, got_wr(s_wr + i),
                   exp_wr(src, dst, 32'(g_data_add), i));
        end
      end
    end
  endtask

  initial begin
    bus.reg_wr = 1'b0;
    bus.reg_addr = 2'd0;
    bus.reg_din = 16'h0;
    bus.vblank = 1'b0;
    test_reset();
    test_basic();
    test_wrap();
    test_zero_len();
    test_wait_ignore();
    test_vblank();
    test_same_cycle();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
